rom_data_arbiter: RTL and testbench

- Shares the single data-side read port of the boot/program ROM between two requesters: M0 = core load unit, M1 = debug/DMA loader.
- Sits between the requesters and the ROM data interface (CE, REQ, HB, ADDR in; GNT, RDATA out).
- Serialises accesses with round-robin arbitration and issues exactly one single-cycle ROM request per transaction.
- Routes the granted read data back to the owner and flags an error if the ROM never grants.

---
 rtl/rom_arb_pkg.sv | 24 ++
 rtl/rom_data_arbiter_if.sv | 68 ++++++
 rtl/rr_arb2.sv | 23 ++
 rtl/rom_data_arbiter.sv | 111 +++++++++++
 tb/tb_rom_data_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rom_arb_pkg.sv
// Shared definitions for the ROM data-port arbiter: FSM encoding, access
// sizes, master indices and the latched command record.
package rom_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    localparam logic [1:0] HB_BYTE = 2'b00;
    localparam logic [1:0] HB_HALF = 2'b01;
    localparam logic [1:0] HB_WORD = 2'b10;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    // One captured ROM access: what is driven onto o_S_ADDR / o_S_HB.
    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  hb;
    } rom_cmd_t;

endpackage

// File: rtl/rom_data_arbiter_if.sv
// Bundle of both requester channels and the ROM data port; the arbiter uses
// the slave view, the surrounding system (or a bench) uses the master view.
interface rom_data_arbiter_if;

    logic        i_M0_REQ;
    logic [31:0] i_M0_ADDR;
    logic [1:0]  i_M0_HB;
    logic        o_M0_GNT;
    logic        o_M0_ERR;
    logic [31:0] o_M0_RDATA;

    logic        i_M1_REQ;
    logic [31:0] i_M1_ADDR;
    logic [1:0]  i_M1_HB;
    logic        o_M1_GNT;
    logic        o_M1_ERR;
    logic [31:0] o_M1_RDATA;

    logic        o_S_CE;
    logic        o_S_REQ;
    logic [31:0] o_S_ADDR;
    logic [1:0]  o_S_HB;
    logic        i_S_GNT;
    logic [31:0] i_S_RDATA;

    modport slave (
        input  i_M0_REQ,
        input  i_M0_ADDR,
        input  i_M0_HB,
        output o_M0_GNT,
        output o_M0_ERR,
        output o_M0_RDATA,
        input  i_M1_REQ,
        input  i_M1_ADDR,
        input  i_M1_HB,
        output o_M1_GNT,
        output o_M1_ERR,
        output o_M1_RDATA,
        output o_S_CE,
        output o_S_REQ,
        output o_S_ADDR,
        output o_S_HB,
        input  i_S_GNT,
        input  i_S_RDATA
    );

    modport master (
        output i_M0_REQ,
        output i_M0_ADDR,
        output i_M0_HB,
        input  o_M0_GNT,
        input  o_M0_ERR,
        input  o_M0_RDATA,
        output i_M1_REQ,
        output i_M1_ADDR,
        output i_M1_HB,
        input  o_M1_GNT,
        input  o_M1_ERR,
        input  o_M1_RDATA,
        input  o_S_CE,
        input  o_S_REQ,
        input  o_S_ADDR,
        input  o_S_HB,
        output i_S_GNT,
        output i_S_RDATA
    );

endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker: on contention the master that
// was not served last wins. Kept generic so the instruction port can reuse it.
module rr_arb2
    import rom_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       winner
);

    always_comb begin
        valid  = |req;
        winner = M0;
        case (req)
            2'b01:   winner = M0;
            2'b10:   winner = M1;
            2'b11:   winner = ~last;
            default: winner = M0;
        endcase
    end

endmodule

// File: rtl/rom_data_arbiter.sv
// Shares the ROM data read port between the core load unit (M0) and the
// debug/DMA loader (M1), one single-cycle ROM request per transaction.
module rom_data_arbiter
    import rom_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic              i_CLK,
    input  logic              i_RSTn,
    rom_data_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t       state;
    logic             owner;
    logic             last;
    rom_cmd_t         cmd_q;
    logic [CNT_W-1:0] cnt;
    logic             s_req_q;

    logic [1:0] req_vec;
    logic       pick_valid;
    logic       pick_winner;
    logic       other_req;
    rom_cmd_t   m0_cmd;
    rom_cmd_t   m1_cmd;
    logic       rom_done;
    logic       timed_out;

    assign req_vec   = {bus.i_M1_REQ, bus.i_M0_REQ};
    assign m0_cmd    = '{addr: bus.i_M0_ADDR, hb: bus.i_M0_HB};
    assign m1_cmd    = '{addr: bus.i_M1_ADDR, hb: bus.i_M1_HB};
    assign other_req = (owner == M1) ? bus.i_M0_REQ : bus.i_M1_REQ;

    rr_arb2 u_pick (
        .req    (req_vec),
        .last   (last),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    // Qualified with reset so a ROM grant landing in the reset cycle is dropped.
    assign rom_done  = i_RSTn && (state == WAIT) && bus.i_S_GNT;
    assign timed_out = i_RSTn && (state == WAIT) && !bus.i_S_GNT && (cnt == CNT_LAST);

    always_ff @(posedge i_CLK) begin
        if (!i_RSTn) begin
            state   <= IDLE;
            owner   <= M0;
            last    <= M1;
            cmd_q   <= '0;
            cnt     <= '0;
            s_req_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner   <= pick_winner;
                        cmd_q   <= (pick_winner == M1) ? m1_cmd : m0_cmd;
                        s_req_q <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    s_req_q <= 1'b0;
                    cnt     <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    // Grant takes precedence over a coincident timeout; the
                    // owner's own REQ is not looked at in its grant cycle.
                    if (bus.i_S_GNT) begin
                        last <= owner;
                        if (other_req) begin
                            owner   <= ~owner;
                            cmd_q   <= (owner == M1) ? m0_cmd : m1_cmd;
                            s_req_q <= 1'b1;
                            state   <= ISSUE;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (cnt == CNT_LAST) begin
                        last  <= owner;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    s_req_q <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_S_CE   = s_req_q;
    assign bus.o_S_REQ  = s_req_q;
    assign bus.o_S_ADDR = cmd_q.addr;
    assign bus.o_S_HB   = cmd_q.hb;

    assign bus.o_M0_GNT   = rom_done && (owner == M0);
    assign bus.o_M1_GNT   = rom_done && (owner == M1);
    assign bus.o_M0_ERR   = timed_out && (owner == M0);
    assign bus.o_M1_ERR   = timed_out && (owner == M1);
    assign bus.o_M0_RDATA = bus.o_M0_GNT ? bus.i_S_RDATA : 32'd0;
    assign bus.o_M1_RDATA = bus.o_M1_GNT ? bus.i_S_RDATA : 32'd0;

endmodule

// File: tb/tb_rom_data_arbiter.sv
// Scoreboard bench for rom_data_arbiter: requests push expected responses,
// a negedge monitor pops and compares against a ROM content function.
module tb_rom_data_arbiter;
    import rom_arb_pkg::*;

    localparam int TO = 4;

    logic i_CLK = 1'b0;
    logic i_RSTn;

    rom_data_arbiter_if bus ();

    rom_data_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .i_CLK  (i_CLK),
        .i_RSTn (i_RSTn),
        .bus    (bus)
    );

    always #5 i_CLK = ~i_CLK;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  hb;
        bit          err;
    } exp_t;

    typedef struct {
        bit m;
        int c;
    } glog_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    exp_t        expq0[$];
    exp_t        expq1[$];
    glog_t       grant_log[$];
    bit          pending[2];
    int          other_served[2];
    int          sreq_cnt = 0;
    int          sreq_cyc = 0;
    logic [31:0] sreq_addr;
    logic [1:0]  sreq_hb;
    bit          rom_mute = 1'b0;
    bit          force_gnt = 1'b0;
    int          rom_delay = 1;
    int          rom_left = 0;
    logic [31:0] rom_a;
    logic [1:0]  rom_h;
    int          ts, td, ts0, td0, ts1, td1, ta, tb;

    always @(posedge i_CLK) cyc <= cyc + 1;

    function automatic logic [31:0] rom_fn(input logic [31:0] a, input logic [1:0] h);
        return (a * 32'h9E3779B1) ^ 32'hDEADBEEF ^ {h, 30'd0};
    endfunction

    function automatic logic [1:0] pickHb();
        case ($urandom_range(0, 3))
            0:       return HB_BYTE;
            1:       return HB_HALF;
            2:       return HB_WORD;
            default: return 2'b11;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_s_ce"},    {31'd0, bus.o_S_CE},   32'd0);
        checkOutput({tag, "_s_req"},   {31'd0, bus.o_S_REQ},  32'd0);
        checkOutput({tag, "_s_addr"},  bus.o_S_ADDR,          32'd0);
        checkOutput({tag, "_s_hb"},    {30'd0, bus.o_S_HB},   32'd0);
        checkOutput({tag, "_m0_gnt"},  {31'd0, bus.o_M0_GNT}, 32'd0);
        checkOutput({tag, "_m0_err"},  {31'd0, bus.o_M0_ERR}, 32'd0);
        checkOutput({tag, "_m0_data"}, bus.o_M0_RDATA,        32'd0);
        checkOutput({tag, "_m1_gnt"},  {31'd0, bus.o_M1_GNT}, 32'd0);
        checkOutput({tag, "_m1_err"},  {31'd0, bus.o_M1_ERR}, 32'd0);
        checkOutput({tag, "_m1_data"}, bus.o_M1_RDATA,        32'd0);
    endtask

    // ROM model: grants rom_delay cycles after a CE&REQ cycle with data derived
    // from the captured address and size; junk data on every other cycle.
    always @(posedge i_CLK) begin
        bus.i_S_GNT   <= force_gnt;
        bus.i_S_RDATA <= $urandom;
        if (bus.o_S_CE && bus.o_S_REQ && !rom_mute) begin
            if (rom_delay <= 1) begin
                bus.i_S_GNT   <= 1'b1;
                bus.i_S_RDATA <= rom_fn(bus.o_S_ADDR, bus.o_S_HB);
            end else begin
                rom_left <= rom_delay - 1;
                rom_a    <= bus.o_S_ADDR;
                rom_h    <= bus.o_S_HB;
            end
        end else if (rom_left != 0) begin
            rom_left <= rom_left - 1;
            if (rom_left == 1) begin
                bus.i_S_GNT   <= 1'b1;
                bus.i_S_RDATA <= rom_fn(rom_a, rom_h);
            end
        end
    end

    task automatic scoreMaster(input bit m, input logic g, input logic e, input logic [31:0] rd);
        exp_t x;
        bit   empty;
        if (g || e) begin
            empty = (m == M1) ? (expq1.size() == 0) : (expq0.size() == 0);
            if (empty) begin
                checks++;
                errors++;
                $display("[TB] FAIL m%0d_unexpected: got gnt=%0b err=%0b, expected no response (cycle %0d)", m, g, e, cyc);
            end else begin
                x = (m == M1) ? expq1.pop_front() : expq0.pop_front();
                checkOutput($sformatf("m%0d_kind", m), {30'd0, g, e}, x.err ? 32'd1 : 32'd2);
                if (g) checkOutput($sformatf("m%0d_rdata", m), rd, rom_fn(x.addr, x.hb));
                pending[m]      = 1'b0;
                other_served[m] = 0;
                if (pending[!m]) begin
                    other_served[!m]++;
                    checkOutput($sformatf("m%0d_starved", !m), {31'd0, other_served[!m] > 1}, 32'd0);
                end
            end
            if (g) grant_log.push_back('{m, cyc});
        end
    endtask

    always @(negedge i_CLK) begin
        if (!bus.o_M0_GNT) checkOutput("m0_rdata_zero", bus.o_M0_RDATA, 32'd0);
        if (!bus.o_M1_GNT) checkOutput("m1_rdata_zero", bus.o_M1_RDATA, 32'd0);
        checkOutput("gnt_onehot", {31'd0, bus.o_M0_GNT & bus.o_M1_GNT}, 32'd0);
        checkOutput("s_ce_vs_req", {31'd0, bus.o_S_CE}, {31'd0, bus.o_S_REQ});
        if (bus.o_S_REQ) begin
            sreq_cnt++;
            sreq_cyc  = cyc;
            sreq_addr = bus.o_S_ADDR;
            sreq_hb   = bus.o_S_HB;
        end
        scoreMaster(M0, bus.o_M0_GNT, bus.o_M0_ERR, bus.o_M0_RDATA);
        scoreMaster(M1, bus.o_M1_GNT, bus.o_M1_ERR, bus.o_M1_RDATA);
    end

    task automatic applyStimulus(input bit m, input logic [31:0] a, input logic [1:0] h,
                                 input bit exp_err, output int t_start, output int t_done);
        exp_t x;
        bit   done;
        @(posedge i_CLK);
        #1;
        x.addr = a;
        x.hb   = h;
        x.err  = exp_err;
        if (m == M0) begin
            bus.i_M0_REQ  = 1'b1;
            bus.i_M0_ADDR = a;
            bus.i_M0_HB   = h;
            expq0.push_back(x);
        end else begin
            bus.i_M1_REQ  = 1'b1;
            bus.i_M1_ADDR = a;
            bus.i_M1_HB   = h;
            expq1.push_back(x);
        end
        pending[m] = 1'b1;
        t_start    = cyc;
        done       = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge i_CLK);
            done = (m == M1) ? (bus.o_M1_GNT || bus.o_M1_ERR) : (bus.o_M0_GNT || bus.o_M0_ERR);
        end
        t_done = cyc;
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL m%0d_no_response: got no GNT/ERR in 64 cycles, expected one", m);
        end
    endtask

    task automatic dropReq(input bit m);
        @(posedge i_CLK);
        #1;
        if (m == M0) begin
            bus.i_M0_REQ  = 1'b0;
            bus.i_M0_ADDR = $urandom;
            bus.i_M0_HB   = 2'b00;
        end else begin
            bus.i_M1_REQ  = 1'b0;
            bus.i_M1_ADDR = $urandom;
            bus.i_M1_HB   = 2'b00;
        end
    endtask

    task automatic resetDut();
        @(posedge i_CLK);
        #1;
        i_RSTn = 1'b0;
        expq0.delete();
        expq1.delete();
        pending         = '{default: 1'b0};
        other_served    = '{default: 0};
        @(negedge i_CLK);
        @(negedge i_CLK);
        checkAllZero("reset");
        @(posedge i_CLK);
        #1;
        i_RSTn = 1'b1;
    endtask

    task automatic randomMaster(input bit m, input int n);
        int gap, a0, a1;
        for (int i = 0; i < n; i++) begin
            applyStimulus(m, $urandom, pickHb(), 1'b0, a0, a1);
            gap = $urandom_range(0, 2);
            if (gap != 0) begin
                dropReq(m);
                repeat (gap - 1) @(posedge i_CLK);
            end
        end
        dropReq(m);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        i_RSTn        = 1'b0;
        bus.i_M0_REQ  = 1'b0;
        bus.i_M0_ADDR = '0;
        bus.i_M0_HB   = '0;
        bus.i_M1_REQ  = 1'b0;
        bus.i_M1_ADDR = '0;
        bus.i_M1_HB   = '0;
        repeat (3) @(posedge i_CLK);
        @(negedge i_CLK);
        checkAllZero("por");
        @(posedge i_CLK);
        #1;
        i_RSTn = 1'b1;

        $display("[TB] single M0 access");
        sreq_cnt = 0;
        applyStimulus(M0, 32'h10, HB_WORD, 1'b0, ts, td);
        checkOutput("t1_latency", td - ts, 32'd2);
        checkOutput("t1_sreq_cycle", sreq_cyc - ts, 32'd1);
        checkOutput("t1_sreq_addr", sreq_addr, 32'h10);
        dropReq(M0);
        repeat (3) @(negedge i_CLK);
        checkOutput("t1_sreq_count", sreq_cnt, 32'd1);

        $display("[TB] simultaneous requests after reset");
        resetDut();
        fork
            begin applyStimulus(M0, 32'h100, HB_WORD, 1'b0, ts0, td0); dropReq(M0); end
            begin applyStimulus(M1, 32'h200, HB_HALF, 1'b0, ts1, td1); dropReq(M1); end
        join
        checkOutput("t2_m0_latency", td0 - ts0, 32'd2);
        checkOutput("t2_m1_latency", td1 - ts0, 32'd4);
        checkOutput("t2_m1_sreq_cycle", sreq_cyc - ts0, 32'd3);

        $display("[TB] continuous alternation");
        grant_log.delete();
        fork
            begin
                for (int i = 0; i < 3; i++) applyStimulus(M0, $urandom, HB_WORD, 1'b0, ta, tb);
                dropReq(M0);
            end
            begin
                for (int i = 0; i < 3; i++) applyStimulus(M1, $urandom, HB_WORD, 1'b0, ts1, td1);
                dropReq(M1);
            end
        join
        checkOutput("t3_grant_count", grant_log.size(), 32'd6);
        for (int i = 0; i < grant_log.size() && i < 6; i++) begin
            checkOutput($sformatf("t3_order_%0d", i), {31'd0, grant_log[i].m}, i % 2);
            if (i > 0) checkOutput($sformatf("t3_spacing_%0d", i), grant_log[i].c - grant_log[i-1].c, 32'd2);
        end

        $display("[TB] timeout on M1");
        rom_mute = 1'b1;
        applyStimulus(M1, 32'h300, HB_WORD, 1'b1, ts, td);
        checkOutput("t4_err_latency", td - ts, 1 + TO);
        dropReq(M1);
        rom_mute = 1'b0;
        applyStimulus(M0, 32'h44, HB_HALF, 1'b0, ts, td);
        checkOutput("t4_m0_after_err", td - ts, 32'd2);
        dropReq(M0);

        $display("[TB] grant coinciding with timeout");
        rom_delay = TO;
        applyStimulus(M0, 32'h88, HB_WORD, 1'b0, ts, td);
        checkOutput("t5_tie_latency", td - ts, 1 + TO);
        dropReq(M0);
        rom_delay = 1;

        $display("[TB] reset during WAIT");
        rom_mute = 1'b1;
        @(posedge i_CLK);
        #1;
        bus.i_M0_REQ  = 1'b1;
        bus.i_M0_ADDR = 32'h55;
        bus.i_M0_HB   = HB_WORD;
        repeat (2) @(posedge i_CLK);
        #1;
        force_gnt = 1'b1;
        @(posedge i_CLK);
        #1;
        i_RSTn       = 1'b0;
        bus.i_M0_REQ = 1'b0;
        @(negedge i_CLK);
        checkOutput("t6_gnt_in_reset", {31'd0, bus.o_M0_GNT}, 32'd0);
        @(negedge i_CLK);
        checkAllZero("t6_reset");
        @(posedge i_CLK);
        #1;
        i_RSTn = 1'b1;
        @(negedge i_CLK);
        checkAllZero("t6_idle_gnt");
        force_gnt = 1'b0;
        rom_mute  = 1'b0;
        applyStimulus(M0, 32'h60, HB_WORD, 1'b0, ts, td);
        checkOutput("t6_recover_latency", td - ts, 32'd2);
        dropReq(M0);

        $display("[TB] byte access from M1");
        applyStimulus(M1, 32'h7, HB_BYTE, 1'b0, ts, td);
        checkOutput("t8_s_addr", sreq_addr, 32'h7);
        checkOutput("t8_s_hb", {30'd0, sreq_hb}, 32'd0);
        dropReq(M1);

        $display("[TB] randomized traffic");
        for (int b = 0; b < 2; b++) begin
            rom_delay = b + 1;
            fork
                randomMaster(M0, 15);
                randomMaster(M1, 15);
            join
            repeat (4) @(posedge i_CLK);
        end

        repeat (5) @(posedge i_CLK);
        checkOutput("queues_empty", expq0.size() + expq1.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
